// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification for the
// sequential ALU and its iterative multiply/divide engine.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1011;
    localparam logic [3:0] ALU_REMU = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between operand fetch, the sequential ALU and writeback.
interface alu_seq_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, opcode, operand1, operand2, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, opcode, operand1, operand2, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: LSB-first shift-add multiply and MSB-first restoring divide,
// one bit per step; res/last expose the value produced by the current step.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res
);

    // hi: product accumulator / partial remainder
    // lo: multiplier / dividend shifting into quotient
    // dv: multiplicand (shifted left) / divisor
    logic [3:0]       op_r;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi, lo, dv;
    logic [WIDTH-1:0] hi_n, lo_n, dv_n;
    logic [WIDTH:0]   sh, diff;
    logic             fits;

    always_comb begin
        sh   = {hi, lo[WIDTH-1]};
        diff = sh - {1'b0, dv};
        fits = ~diff[WIDTH];
        if (op_r == ALU_MUL) begin
            hi_n = hi + (lo[0] ? dv : '0);
            lo_n = lo >> 1;
            dv_n = dv << 1;
        end else begin
            // A zero divisor always "fits", giving all-ones quotient and remainder = dividend
            hi_n = fits ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], fits};
            dv_n = dv;
        end
        if (op_r == ALU_DIVU) begin
            res = lo_n;
        end else begin
            res = hi_n;
        end
        last = step && (cnt == SHW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= '0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            dv   <= '0;
        end else if (start) begin
            op_r <= op;
            cnt  <= '0;
            hi   <= '0;
            lo   <= (op == ALU_MUL) ? b : a;
            dv   <= (op == ALU_MUL) ? a : b;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_n;
            lo  <= lo_n;
            dv  <= dv_n;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops plus iterative
// mul/divu/remu, one operation in flight, result held until accepted.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);

    state_t           state, state_n;
    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] single_res, res_d, result_r, eng_res;
    logic             single_ill, ill_d, illegal_r, zero_r;
    logic             res_load, start, eng_last;

    assign a     = bus.operand1;
    assign b     = bus.operand2;
    assign shamt = bus.operand2[SHW-1:0];

    always_comb begin
        single_res = '0;
        single_ill = 1'b0;
        case (bus.opcode)
            ALU_ADD:  single_res = a + b;
            ALU_SUB:  single_res = a - b;
            ALU_AND:  single_res = a & b;
            ALU_OR:   single_res = a | b;
            ALU_XOR:  single_res = a ^ b;
            ALU_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, a < b};
            ALU_SLL:  single_res = a << shamt;
            ALU_SRL:  single_res = a >> shamt;
            ALU_SRA:  single_res = $unsigned($signed(a) >>> shamt);
            default:  single_ill = ~is_iter(bus.opcode);
        endcase
    end

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        res_load = 1'b0;
        res_d    = single_res;
        ill_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (is_iter(bus.opcode)) begin
                        start   = 1'b1;
                        state_n = S_BUSY;
                    end else begin
                        res_load = 1'b1;
                        ill_d    = single_ill;
                        state_n  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (eng_last) begin
                    res_load = 1'b1;
                    res_d    = eng_res;
                    state_n  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            result_r  <= '0;
            zero_r    <= 1'b1;
            illegal_r <= 1'b0;
        end else begin
            state <= state_n;
            if (res_load) begin
                result_r  <= res_d;
                zero_r    <= (res_d == '0);
                illegal_r <= ill_d;
            end
        end
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .step  (state == S_BUSY),
        .op    (bus.opcode),
        .a     (a),
        .b     (b),
        .last  (eng_last),
        .res   (eng_res)
    );

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.illegal   = illegal_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_res = '0;
    logic        exp_ill = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic ill);
        logic [63:0] wide;
        logic [31:0] r;
        int unsigned n;
        n   = b % 32;
        ill = 1'b0;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h6: return (a < b) ? 32'd1 : 32'd0;
            4'h7: begin wide = {32'h0, a} * (64'd1 << n); return wide[31:0]; end
            4'h8: return a / (32'd1 << n);
            4'h9: begin
                r = a;
                for (int unsigned i = 0; i < n; i++) r = {r[31], r[31:1]};
                return r;
            end
            4'hA: begin wide = {32'h0, a} * {32'h0, b}; return wide[31:0]; end
            4'hB: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'hC: return (b == 0) ? a : a % b;
            default: begin ill = 1'b1; return 32'h0; end
        endcase
    endfunction

    // Output checker: every cycle a result is presented it must match the model
    always @(posedge clk) begin
        #2;
        if (rst_n && bus.out_valid) begin
            if (!exp_valid) begin
                check("stale_out_valid", 32'd1, 32'd0);
            end else begin
                check("result", bus.result, exp_res);
                check("zero", {31'h0, bus.zero}, {31'h0, exp_res == 32'h0});
                check("illegal", {31'h0, bus.illegal}, {31'h0, exp_ill});
            end
        end
    end

    task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit, input bit use_lit,
                       input int hold);
        int cyc, exp_lat;
        bit busy_bad, ok;
        logic [31:0] held;
        exp_res = model(op, a, b, exp_ill);
        exp_lat = (op == 4'hA || op == 4'hB || op == 4'hC) ? W + 1 : 1;
        @(negedge clk);
        check({name, "_in_ready"}, {31'h0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.operand1 = a;
        bus.operand2 = b;
        exp_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.opcode   = 4'($urandom);
        bus.operand1 = $urandom;
        bus.operand2 = $urandom;
        cyc = 0;
        busy_bad = 1'b0;
        while (cyc <= 100) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) break;
            if (bus.in_ready) busy_bad = 1'b1;
        end
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_in_ready_busy"}, {31'h0, busy_bad}, 32'd0);
        if (use_lit) check({name, "_literal"}, bus.result, lit);
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            held = bus.result;
            ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!(bus.out_valid && !bus.in_ready && bus.result == held)) ok = 1'b0;
                bus.in_valid = 1'b1;
                bus.opcode   = 4'h0;
                bus.operand1 = $urandom;
                bus.operand2 = $urandom;
            end
            check({name, "_hold_stable"}, {31'h0, ok}, 32'd1);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check({name, "_handover"}, {30'h0, bus.out_valid, bus.in_ready}, 32'd1);
        exp_valid = 1'b0;
    endtask

    initial begin
        int seen;
        logic dummy;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'h0);
        check("rst_zero", {31'h0, bus.zero}, 32'd1);
        check("rst_illegal", {31'h0, bus.illegal}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
        run("sub",      4'h1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0);
        run("and",      4'h2, 32'hF0F0, 32'hFF00, 32'hF000, 1, 0);
        run("or",       4'h3, 32'hF0F0, 32'hFF00, 32'hFFF0, 1, 0);
        run("slt",      4'h5, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 0);
        run("sltu",     4'h6, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
        run("sra",      4'h9, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 0);
        run("sll_mask", 4'h7, 32'h1, 32'h21, 32'h2, 1, 0);
        run("srl",      4'h8, 32'h8000_0000, 32'd31, 32'h1, 1, 0);
        run("mul",      4'hA, 32'h0001_0003, 32'h5, 32'h0005_000F, 1, 0);
        run("mul_ones", 4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1, 0);
        run("divu",     4'hB, 32'd100, 32'd7, 32'd14, 1, 0);
        run("remu",     4'hC, 32'd100, 32'd7, 32'd2, 1, 0);
        run("divu_z",   4'hB, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 1, 0);
        run("remu_z",   4'hC, 32'h1234, 32'h0, 32'h1234, 1, 0);
        run("xor_bp",   4'h4, 32'hFF00, 32'h0FF0, 32'hF0F0, 1, 10);
        run("divu_bp",  4'hB, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1, 3);
        run("add_next", 4'h0, 32'd20, 32'd22, 32'd42, 1, 0);

        // Reset in the middle of a divide must discard it entirely
        exp_res = model(4'hB, 32'd1000, 32'd3, exp_ill);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = 4'hB;
        bus.operand1 = 32'd1000;
        bus.operand2 = 32'd3;
        exp_valid    = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        exp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'h0, bus.in_ready}, 32'd1);
        check("midrst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        check("midrst_result", bus.result, 32'h0);
        check("midrst_zero", {31'h0, bus.zero}, 32'd1);
        check("midrst_illegal", {31'h0, bus.illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrst_no_stale", seen, 32'd0);

        run("illegal",  4'hE, 32'h1234, 32'h5678, 32'h0, 1, 0);
        check("model_pin_ill", {31'h0, exp_ill}, 32'd1);
        check("model_pin_sra", model(4'h9, 32'h8000_0000, 32'd4, dummy), 32'hF800_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath ALU.
- Supports WIDTH-bit operands, a 4-bit opcode space that keeps the legacy ALU encodings, shift and unsigned-compare ops, and iterative multiply/divide/remainder.
- Sits between the decode/operand-fetch stage and writeback. One operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4, power of 2).
- SHW, $clog2(WIDTH), shift-amount width, derived; do not override.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request; 1 only in IDLE.
- opcode  input  4  operation select; encodings under Behaviour.
- operand1  input  WIDTH  first operand (rs1).
- operand2  input  WIDTH  second operand (rs2 / shift amount).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- illegal  output  1  opcode was unassigned; qualified by out_valid.

Behaviour:
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt (signed), 0110 sltu.
  - 0111 sll, 1000 srl, 1001 sra; shift amount is operand2[SHW-1:0].
  - 1010 mul (low WIDTH bits of the product).
  - 1011 divu (unsigned quotient), 1100 remu (unsigned remainder).
  - 1101–1111 illegal.
- Arithmetic: add/sub wrap modulo 2^WIDTH, no overflow flag. slt/sltu return 1 or 0, zero-extended.
- Handshakes: accept on in_valid && in_ready. Operands and opcode are captured at accept, so later input changes are ignored. Result handover on out_valid && out_ready.
- FSM IDLE/BUSY/DONE:
  - IDLE: in_ready=1. On accept of a single-cycle op (including illegal): compute, register result, go to DONE. On accept of mul/divu/remu: load the iteration registers, counter=0, go to BUSY.
  - BUSY: one iteration per cycle, counter += 1. After WIDTH iterations (counter == WIDTH-1 on the last), register the result and go to DONE.
  - DONE: out_valid=1. result, zero and illegal are held stable until out_ready=1, then go to IDLE.
- Multiply: shift-add, one multiplier bit per cycle, LSB first.
- Divide: restoring, one quotient bit per cycle, MSB first.
- Latency from accept to out_valid:
  - single-cycle ops: 1 cycle.
  - mul/divu/remu: WIDTH+1 cycles.
- No request/response overlap: in_ready=0 in BUSY and DONE, including the DONE cycle where out_ready=1. A new accept is possible the cycle after handover.
- Divide by zero: divu returns all ones, remu returns operand1. Both take the full WIDTH+1 cycles. illegal=0.
- Illegal opcode: result=0, zero=1, illegal=1, latency 1.
- Shift amount ≥ WIDTH cannot occur because only the low SHW bits are used. sra replicates operand1[WIDTH-1].
- zero is computed from the registered result and is never X. There is no X output for any opcode.
- Reset: asynchronous assert at any time, including mid-BUSY or DONE. State goes to IDLE, the in-flight op is discarded, and no out_valid pulse appears afterwards.
- Reset values: in_ready=1, out_valid=0, result=0, zero=1, illegal=0; counter and iteration registers 0.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams (ALU_ADD … ALU_REMU) with 4-bit width;
  - the FSM state enum (S_IDLE, S_BUSY, S_DONE).
- One sub-module, alu_iter_muldiv: the iterative mul/div engine with start/done, op-select, counter and WIDTH-bit datapath.
- The top level holds the FSM, the single-cycle combinational ops and the output registers.

Test Plan:
- WIDTH=32, add 0xFFFFFFFF+1 and sub 5-7, out_ready=1 → result 0x0 with zero=1; result 0xFFFFFFFE; out_valid exactly 1 cycle after each accept.
- slt 0xFFFFFFFF vs 1 → 1; sltu same operands → 0; sra 0x80000000 by 4 → 0xF8000000; sll by operand2=0x21 → shift by 1.
- mul 0x0001_0003 × 0x0000_0005 → 0x0005_000F; out_valid 33 cycles after accept; in_ready=0 throughout.
- divu 100/7 → 14, remu 100/7 → 2; divu x/0 → 0xFFFFFFFF; remu 0x1234/0 → 0x1234; all take 33 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after DONE → result/out_valid stable, in_ready=0, new in_valid ignored; release → handover, then next request accepted.
- Assert rst_n=0 at BUSY cycle 10 of a divu → immediately in_ready=1, out_valid=0, result=0; after release no stale result; opcode 1110 → result 0, illegal=1, latency 1.
